// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit owning HI/LO: MULT/MULTU/DIV/DIVU/MTHI/MTLO.
// Optional MADD/MSUB on ops 6/7 when MULDIV_MADD_EN is defined.
module mul_div_unit #(
  parameter int MUL_CYCLES = 4,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              flush,
  output logic              busy,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MULDIV_MADD_EN
  localparam logic [2:0] OP_MADD  = 3'd6;
  localparam logic [2:0] OP_MSUB  = 3'd7;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t            state;
  logic [4:0]        cnt;
  logic [DATA_W-1:0] opa;   // multiplicand, or dividend shifting into quotient
  logic [DATA_W-1:0] opb;   // multiplier, or divisor
  logic [DATA_W-1:0] rem;
  logic              msgn, q_neg, r_neg;
`ifdef MULDIV_MADD_EN
  logic              acc_en, acc_sub;
  logic [2*DATA_W-1:0] acc_res;
`endif

  // Sign-extend to 33 bits so one multiplier serves signed and unsigned.
  logic signed [2*DATA_W+1:0] prod_w;
  logic [2*DATA_W-1:0]        prod;
  assign prod_w = $signed({msgn & opa[DATA_W-1], opa}) * $signed({msgn & opb[DATA_W-1], opb});
  assign prod   = prod_w[2*DATA_W-1:0];

`ifdef MULDIV_MADD_EN
  assign acc_res = acc_sub ? ({hi, lo} - prod) : ({hi, lo} + prod);
`endif

  // Restoring division step; extra top bit catches the borrow even when divisor is zero.
  logic [DATA_W:0]   shf;
  logic [DATA_W+1:0] trial;
  logic              borrow;
  assign shf    = {rem, opa[DATA_W-1]};
  assign trial  = {1'b0, shf} - {2'b00, opb};
  assign borrow = trial[DATA_W+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      rem   <= '0;
      msgn  <= 1'b0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
`ifdef MULDIV_MADD_EN
      acc_en  <= 1'b0;
      acc_sub <= 1'b0;
`endif
    end else if (flush) begin
      state <= IDLE;
      busy  <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              opa   <= rs_val;
              opb   <= rt_val;
              msgn  <= (op == OP_MULT);
              cnt   <= 5'(MUL_CYCLES - 1);
              state <= MUL;
              busy  <= 1'b1;
`ifdef MULDIV_MADD_EN
              acc_en <= 1'b0;
`endif
            end
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MSUB: begin
              opa     <= rs_val;
              opb     <= rt_val;
              msgn    <= 1'b1;
              acc_en  <= 1'b1;
              acc_sub <= (op == OP_MSUB);
              cnt     <= 5'(MUL_CYCLES - 1);
              state   <= MUL;
              busy    <= 1'b1;
            end
`endif
            OP_DIV: begin
              opa   <= rs_val[DATA_W-1] ? -rs_val : rs_val;
              opb   <= rt_val[DATA_W-1] ? -rt_val : rt_val;
              q_neg <= rs_val[DATA_W-1] ^ rt_val[DATA_W-1];
              r_neg <= rs_val[DATA_W-1];
              rem   <= '0;
              cnt   <= 5'(DATA_W - 1);
              state <= DIV;
              busy  <= 1'b1;
            end
            OP_DIVU: begin
              opa   <= rs_val;
              opb   <= rt_val;
              q_neg <= 1'b0;
              r_neg <= 1'b0;
              rem   <= '0;
              cnt   <= 5'(DATA_W - 1);
              state <= DIV;
              busy  <= 1'b1;
            end
            OP_MTHI: hi <= rs_val;
            OP_MTLO: lo <= rs_val;
            default: ;
          endcase
        end
        MUL: begin
          if (cnt == '0) begin
`ifdef MULDIV_MADD_EN
            {hi, lo} <= acc_en ? acc_res : prod;
`else
            {hi, lo} <= prod;
`endif
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        DIV: begin
          rem <= borrow ? shf[DATA_W-1:0] : trial[DATA_W-1:0];
          opa <= {opa[DATA_W-2:0], ~borrow};
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 5'd1;
        end
        FIX: begin
          lo    <= q_neg ? -opa : opa;
          hi    <= r_neg ? -rem : rem;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed plan cases plus random ops
// checked against an arithmetic reference model of HI/LO and latency.
module tb_mul_div_unit;

  logic        clk, rst_n, start, flush, busy;
  logic [2:0]  op;
  logic [31:0] rs_val, rt_val, hi, lo;
  int checks = 0;
  int errors = 0;
  logic [31:0] mhi = '0, mlo = '0;

  mul_div_unit #(.MUL_CYCLES(4), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val),
    .rt_val(rt_val), .flush(flush), .busy(busy), .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The pipeline never issues into a busy unit; flag any bench step that would.
  always @(negedge clk)
    if (rst_n === 1'b1)
      assert (!(busy === 1'b1 && start === 1'b1)) else begin
        errors++;
        $error("FAIL start_while_busy observed=1 expected=0");
      end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: HI/LO after an op, and how many cycles busy should be high.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] h, inout logic [31:0] l, output int lat);
    longint sa, sb;
    logic [63:0] p;
    logic [31:0] ua, ub, q, r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    lat = 0;
    case (o)
      3'd0: begin p = 64'(sa * sb); {h, l} = p; lat = 4; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {h, l} = p; lat = 4; end
      3'd2, 3'd3: begin
        ua = (o == 3'd2 && a[31]) ? -a : a;
        ub = (o == 3'd2 && b[31]) ? -b : b;
        q = (ub == 0) ? 32'hFFFFFFFF : ua / ub;
        r = (ub == 0) ? ua : ua % ub;
        if (o == 3'd2 && (a[31] ^ b[31])) q = -q;
        if (o == 3'd2 && a[31]) r = -r;
        l = q; h = r; lat = 33;
      end
      3'd4: h = a;
      3'd5: l = a;
`ifdef MULDIV_MADD_EN
      3'd6: begin p = 64'(sa * sb); {h, l} = {h, l} + p; lat = 4; end
      3'd7: begin p = 64'(sa * sb); {h, l} = {h, l} - p; lat = 4; end
`endif
      default: ;
    endcase
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int lat, n;
    logic [31:0] eh, el;
    eh = mhi; el = mlo;
    model(o, a, b, eh, el, lat);
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk($sformatf("latency op%0d", o), 64'(n), 64'(lat));
    chk($sformatf("hi op%0d a=%h b=%h", o, a, b), 64'(hi), 64'(eh));
    chk($sformatf("lo op%0d a=%h b=%h", o, a, b), 64'(lo), 64'(el));
    mhi = eh; mlo = el;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    #12;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset hi", 64'(hi), 64'(0));
    chk("reset lo", 64'(lo), 64'(0));
    @(negedge clk) rst_n = 1'b1;

    run(3'd1, 32'hFFFFFFFF, 32'h2);
    chk("plan multu hi", 64'(hi), 64'h1);
    chk("plan multu lo", 64'(lo), 64'hFFFFFFFE);
    run(3'd0, -32'sd3, 32'd5);
    chk("plan mult lo", 64'(lo), 64'hFFFFFFF1);
    run(3'd2, -32'sd7, 32'd2);
    chk("plan div lo", 64'(lo), 64'hFFFFFFFD);
    chk("plan div hi", 64'(hi), 64'hFFFFFFFF);
    run(3'd3, 32'd100, 32'd7);
    chk("plan divu lo", 64'(lo), 64'd14);
    run(3'd3, 32'h1234, 32'h0);
    chk("plan divu0 hi", 64'(hi), 64'h1234);
    run(3'd2, 32'h80000000, 32'hFFFFFFFF);
    chk("plan divovf lo", 64'(lo), 64'h80000000);
    run(3'd2, 32'hFFFFFFF0, 32'h0);

    for (int i = 0; i < 40; i++)
      run(3'($urandom_range(0, 5)), pick(), pick());

    // Reserved op is a NOP in the default build.
`ifndef MULDIV_MADD_EN
    run(3'd6, 32'h11, 32'h22);
    run(3'd7, 32'h33, 32'h44);
`endif

    // Flush on busy cycle 10 of a divide.
    run(3'd4, 32'hA5A5A5A5, 32'h0);
    @(negedge clk);
    start = 1'b1; op = 3'd2; rs_val = $urandom; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", 64'(busy), 64'(0));
    chk("flush hi", 64'(hi), 64'hA5A5A5A5);
    chk("flush lo", 64'(lo), 64'(mlo));

    // Flush beats a same-cycle request.
    start = 1'b1; op = 3'd5; rs_val = 32'hDEADBEEF; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush+start lo", 64'(lo), 64'(mlo));
    chk("flush+start busy", 64'(busy), 64'(0));

`ifdef MULDIV_MADD_EN
    run(3'd4, 32'h0, 32'h0);
    run(3'd5, 32'd10, 32'h0);
    run(3'd6, 32'd3, 32'd4);
    chk("plan madd lo", 64'(lo), 64'd22);
    run(3'd7, 32'd5, 32'd5);
    chk("plan msub lo", 64'(lo), 64'hFFFFFFFD);
    chk("plan msub hi", 64'(hi), 64'hFFFFFFFF);
    for (int i = 0; i < 10; i++)
      run(3'($urandom_range(6, 7)), pick(), pick());
`endif

    // Asynchronous reset in the middle of a divide.
    run(3'd4, 32'h5A5A5A5A, 32'h0);
    @(negedge clk);
    start = 1'b1; op = 3'd3; rs_val = 32'd1000; rt_val = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'(0));
    chk("async rst hi", 64'(hi), 64'(0));
    chk("async rst lo", 64'(lo), 64'(0));
    mhi = '0; mlo = '0;
    @(negedge clk) rst_n = 1'b1;
    run(3'd3, 32'd1000, 32'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
